// File: rtl/instruction_fetch_unit.sv
// Instruction fetch FSM: requests a word at pc, holds it in ir until consumed, then pulses the PC update.
// Optional JMP decode in the update cycle is enabled by defining BRANCH_DECODE_EN.
module instruction_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  pc,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        inc_pc,
    output logic        load_pc,
    output logic [7:0]  load_addr
);

    typedef enum logic [1:0] {IDLE, REQ, ISSUE, UPDATE} state_t;

    localparam logic [3:0] OP_JMP = 4'hC;

    state_t      state, state_nxt;
    logic [15:0] ir_nxt;
    logic        mem_req_nxt, ir_valid_nxt, inc_nxt, is_jmp;

    // pc is only looked at while a request is outstanding
    assign mem_addr = pc;

`ifdef BRANCH_DECODE_EN
    assign is_jmp = (ir[15:12] == OP_JMP);
`else
    assign is_jmp = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        case (state)
            IDLE:   if (enable) state_nxt = REQ;
            REQ: begin
                if (mem_ack) begin
                    state_nxt = ISSUE;
                    ir_nxt    = mem_rdata;
                end
            end
            ISSUE:  if (ir_ready) state_nxt = UPDATE;
            UPDATE: state_nxt = enable ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
        // outputs are registered: derive them from the state being entered
        mem_req_nxt  = (state_nxt == REQ);
        ir_valid_nxt = (state_nxt == ISSUE);
        inc_nxt      = (state_nxt == UPDATE) && !is_jmp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ir       <= 16'h0000;
            mem_req  <= 1'b0;
            ir_valid <= 1'b0;
            inc_pc   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ir       <= ir_nxt;
            mem_req  <= mem_req_nxt;
            ir_valid <= ir_valid_nxt;
            inc_pc   <= inc_nxt;
        end
    end

`ifdef BRANCH_DECODE_EN
    logic       ld_nxt;
    logic [7:0] la_nxt;

    assign ld_nxt = (state_nxt == UPDATE) && is_jmp;
    assign la_nxt = ld_nxt ? ir[7:0] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_pc   <= 1'b0;
            load_addr <= 8'h00;
        end else begin
            load_pc   <= ld_nxt;
            load_addr <= la_nxt;
        end
    end
`else
    assign load_pc   = 1'b0;
    assign load_addr = 8'h00;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 clk  input  1  single clock; all state SHALL change only on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; SHALL be sampled on rising clk edge only.
REQ-003 enable  input  1  fetch enable; 1 = keep fetching sequential instructions.
REQ-004 pc  input  8  current instruction address from program counter.
REQ-005 mem_req  output  1  instruction memory read request.
REQ-006 mem_addr  output  8  read address, valid while mem_req=1.
REQ-007 mem_ack  input  1  memory read completion; mem_rdata valid in same cycle.
REQ-008 mem_rdata  input  16  instruction word; opcode = [15:12], operand = [7:0].
REQ-009 ir  output  16  instruction register.
REQ-010 ir_valid  output  1  ir holds an unconsumed instruction.
REQ-011 ir_ready  input  1  downstream accepts ir.
REQ-012 inc_pc  output  1  one-cycle pulse: program counter PC+1.
REQ-013 load_pc  output  1  one-cycle pulse: program counter loads load_addr.
REQ-014 load_addr  output  8  new PC value, valid while load_pc=1.

Function
REQ-015 FSM states SHALL be IDLE, REQ, ISSUE, UPDATE; all outputs except mem_addr SHALL be registered.
REQ-016 IDLE: if enable=1 go to REQ next cycle; else remain in IDLE; mem_req=0, ir_valid=0.
REQ-017 REQ: mem_req=1; mem_addr SHALL equal pc combinationally; hold until mem_ack=1.
REQ-018 REQ with mem_ack=1: capture mem_rdata into ir at that edge, go to ISSUE; mem_req drops same edge.
REQ-019 mem_ack outside REQ SHALL be ignored; ir unchanged.
REQ-020 ISSUE: ir_valid=1; ir stable; on ir_ready=1 go to UPDATE; ir_valid drops same edge.
REQ-021 UPDATE: exactly one of inc_pc/load_pc =1 for that single cycle; then REQ if enable=1, else IDLE.
REQ-022 inc_pc and load_pc SHALL never both be 1; neither asserted outside UPDATE.
REQ-023 pc SHALL be sampled only in REQ, so PC updated at UPDATE's closing edge is the next fetch address.
REQ-024 Latency: enable->mem_req 1 cycle; mem_ack->ir_valid 1 cycle; ir_ready->pulse 1 cycle; minimum 3 cycles/instruction with ack and ready held high.
REQ-025 enable deassertion SHALL not abort an in-progress fetch; REQ/ISSUE/UPDATE complete, then IDLE.
REQ-026 pc=8'hFF SHALL be fetched normally; wrap to 8'h00 is the program counter's responsibility.
REQ-027 ir SHALL hold its last value after handshake until the next capture.

Reset
REQ-028 reset=1 at a clk edge SHALL force IDLE, ir=16'h0000, mem_req=0, ir_valid=0, inc_pc=0, load_pc=0, load_addr=8'h00, from any state.
REQ-029 Reset mid-REQ or mid-ISSUE SHALL discard the transaction; a coincident mem_ack SHALL not load ir.

Configuration
REQ-030 Macro BRANCH_DECODE_EN defined: in UPDATE, if ir[15:12]=4'hC (JMP), load_pc=1 and load_addr=ir[7:0], inc_pc=0; other opcodes use inc_pc.
REQ-031 Macro BRANCH_DECODE_EN undefined: UPDATE always pulses inc_pc; load_pc and load_addr tied to 0.

Verification
REQ-032 Reset, enable=1, pc=8'h00, ack/ready tied 1 -> mem_req at cycle 1, ir_valid at cycle 2, inc_pc pulse at cycle 3, mem_req again at cycle 4.
REQ-033 mem_ack delayed 5 cycles, rdata=16'h3A5F -> mem_req/mem_addr held 5 cycles; ir=16'h3A5F, ir_valid 1 cycle after ack.
REQ-034 ir_ready held 0 for 4 cycles in ISSUE -> ir_valid and ir stable, no inc_pc until ready.
REQ-035 BRANCH_DECODE_EN defined, rdata=16'hC042 -> load_pc=1, load_addr=8'h42, inc_pc=0; undefined -> inc_pc=1, load_pc=0.
REQ-036 reset=1 in ISSUE with ir_ready=1 and in REQ with mem_ack=1 -> IDLE next cycle, no pulse, ir=16'h0000.
REQ-037 enable dropped in REQ -> fetch completes through UPDATE, then IDLE with mem_req=0.
